// File: rtl/vga_scan_fetch_if.sv
// Memory read bus between the scan engine and the dual-read bitmap memory.
// The scan engine drives both read addresses every clock. The memory returns
// both words exactly one clock later. There is no valid/ready pair: every
// address is accepted, and every returned word is consumed on the next clock.
interface vga_scan_fetch_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 5
);
    logic [ADDRESS_WIDTH-1:0] address_0_out;
    logic [ADDRESS_WIDTH-1:0] address_1_out;
    logic [DATA_WIDTH-1:0]    data_0_in;
    logic [DATA_WIDTH-1:0]    data_1_in;

    modport master (
        output address_0_out,
        output address_1_out,
        input  data_0_in,
        input  data_1_in
    );

    modport slave (
        input  address_0_out,
        input  address_1_out,
        output data_0_in,
        output data_1_in
    );
endinterface

// File: rtl/vga_scan_fetch.sv
// VGA scan engine for a two-plane bitmap.
// The counters generate 640x480 timing, and the scan position drives both
// plane read addresses. The two returned bits form a palette index.
// Outputs for scan position (h,v) appear two clocks after the counters hold it.
// Optional feature macro: SCAN_FETCH_BORDER_EN. When it is defined, visible
// pixels outside the bitmap show BORDER_COLOR instead of black.
module vga_scan_fetch #(
    parameter int          DATA_WIDTH    = 16,
    parameter int          ADDRESS_WIDTH = 5,
    parameter int          H_WORD_BITS   = 1,
    parameter int          V_ROW_BITS    = 3,
    parameter int          SCALE_SHIFT   = 4,
    parameter int          H_VISIBLE     = 640,
    parameter int          H_FRONT       = 16,
    parameter int          H_SYNC        = 96,
    parameter int          H_BACK        = 48,
    parameter int          V_VISIBLE     = 480,
    parameter int          V_FRONT       = 10,
    parameter int          V_SYNC        = 2,
    parameter int          V_BACK        = 33,
    parameter logic [11:0] COLOR_0       = 12'h000,
    parameter logic [11:0] COLOR_1       = 12'hFFF,
    parameter logic [11:0] COLOR_2       = 12'hF00,
    parameter logic [11:0] COLOR_3       = 12'h00F,
    parameter logic [11:0] BORDER_COLOR  = 12'h444
) (
    input  logic               clock_in,
    input  logic               reset_in,
    vga_scan_fetch_if.master   mem,
    output logic [11:0]        rgb_out,
    output logic               h_sync_out,
    output logic               v_sync_out,
    output logic               video_on_out,
    output logic               frame_start_out
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BIT_W   = $clog2(DATA_WIDTH);

    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]    H_VIS_L  = HW'(H_VISIBLE);
    localparam logic [HW-1:0]    HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0]    HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_VIS_L  = VW'(V_VISIBLE);
    localparam logic [VW-1:0]    VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0]    VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [HW-1:0]    BMP_LX   = HW'(DATA_WIDTH << H_WORD_BITS);
    localparam logic [VW-1:0]    BMP_LY   = VW'(1 << V_ROW_BITS);
    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_WIDTH - 1);

    // Stage 0: scan counters and their combinational decode
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW-1:0] lx;
    logic [VW-1:0] ly;
    logic [V_ROW_BITS-1:0]  row;
    logic [H_WORD_BITS-1:0] word;
    logic             in_bmp0, vis0, hs0, vs0, fs0;
    logic [BIT_W-1:0] bit0;

    // Stage 1: decode registered alongside the memory read
    logic             in_bmp1_q, vis1_q, hs1_q, vs1_q, fs1_q;
    logic [BIT_W-1:0] bit1_q;

    // Stage 2: pixel colour selection feeding the output registers
    logic [1:0]  pix_idx;
    logic [11:0] rgb_d;

    // Next scan position: h wraps every line and v advances on that wrap
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Scan position registers
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Logical pixel coordinates, bitmap membership, timing flags and bit select
    always_comb begin
        lx      = h_q >> SCALE_SHIFT;
        ly      = v_q >> SCALE_SHIFT;
        row     = ly[V_ROW_BITS-1:0];
        word    = lx[BIT_W +: H_WORD_BITS];
        in_bmp0 = (lx < BMP_LX) && (ly < BMP_LY);
        vis0    = (h_q < H_VIS_L) && (v_q < V_VIS_L);
        hs0     = !((h_q >= HS_START) && (h_q < HS_END));
        vs0     = !((v_q >= VS_START) && (v_q < VS_END));
        fs0     = (h_q == '0) && (v_q == '0);
        bit0    = BIT_TOP - lx[BIT_W-1:0];
    end

    // Both planes read the same location. The addresses are parked at 0 off-bitmap.
    assign mem.address_0_out = in_bmp0 ? {1'b0, row, word} : '0;
    assign mem.address_1_out = in_bmp0 ? {1'b1, row, word} : '0;

    // Delay the decode by one clock so it lines up with the returned words
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            in_bmp1_q <= 1'b0;
            vis1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            fs1_q     <= 1'b0;
            bit1_q    <= '0;
        end else begin
            in_bmp1_q <= in_bmp0;
            vis1_q    <= vis0;
            hs1_q     <= hs0;
            vs1_q     <= vs0;
            fs1_q     <= fs0;
            bit1_q    <= bit0;
        end
    end

    // Combine the plane bits into a palette index and pick the pixel colour
    always_comb begin
        pix_idx = {mem.data_1_in[bit1_q], mem.data_0_in[bit1_q]};
        rgb_d   = 12'h000;
        if (vis1_q) begin
            if (in_bmp1_q) begin
                case (pix_idx)
                    2'd0:    rgb_d = COLOR_0;
                    2'd1:    rgb_d = COLOR_1;
                    2'd2:    rgb_d = COLOR_2;
                    default: rgb_d = COLOR_3;
                endcase
            end else begin
`ifdef SCAN_FETCH_BORDER_EN
                rgb_d = BORDER_COLOR;
`else
                rgb_d = 12'h000;
`endif
            end
        end
    end

    // Output registers: colour, syncs, video enable and frame pulse stay aligned
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            rgb_out         <= 12'h000;
            h_sync_out      <= 1'b1;
            v_sync_out      <= 1'b1;
            video_on_out    <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            rgb_out         <= rgb_d;
            h_sync_out      <= hs1_q;
            v_sync_out      <= vs1_q;
            video_on_out    <= vis1_q;
            frame_start_out <= fs1_q;
        end
    end

`ifndef SCAN_FETCH_BORDER_EN
    // The border colour only matters when the border feature is built in
    logic unused_border;
    assign unused_border = ^BORDER_COLOR;
`endif
endmodule

// File: tb/tb_vga_scan_fetch.sv
// Directed bench for vga_scan_fetch. The horizontal timing is the full 800-clock line.
// The vertical timing is cut to 56 lines (50 visible, v_sync on lines 52..53),
// so a whole frame lasts 44800 clocks.
module tb_vga_scan_fetch;
    localparam int FRAME = 800 * 56;

`ifdef SCAN_FETCH_BORDER_EN
    localparam logic [11:0] BORDER_EXP = 12'h444;
`else
    localparam logic [11:0] BORDER_EXP = 12'h000;
`endif

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic [11:0] rgb_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        video_on_out;
    logic        frame_start_out;

    int checks = 0;
    int errors = 0;
    int oh = 0;
    int ov = 0;

    logic [15:0] mem [32];

    localparam int NPIX = 15;
    int          tx [NPIX];
    int          ty [NPIX];
    logic [11:0] tc [NPIX];

    vga_scan_fetch_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(5)) bus ();

    vga_scan_fetch #(
        .V_VISIBLE(50), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .mem             (bus),
        .rgb_out         (rgb_out),
        .h_sync_out      (h_sync_out),
        .v_sync_out      (v_sync_out),
        .video_on_out    (video_on_out),
        .frame_start_out (frame_start_out)
    );

    // clock and memory model (1-clock read latency)
    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) begin
        bus.data_0_in <= mem[bus.address_0_out];
        bus.data_1_in <= mem[bus.address_1_out];
    end

    // advance one clock and track the output scan position
    task automatic step();
        @(posedge clock_in);
        #1;
        if (oh == 799) begin
            oh = 0;
            ov = (ov == 55) ? 0 : ov + 1;
        end else begin
            oh = oh + 1;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (5) @(posedge clock_in);
        #1;
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb_out); end
        checks++; if (h_sync_out !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", h_sync_out); end
        checks++; if (v_sync_out !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", v_sync_out); end
        checks++; if (video_on_out !== 1'b0) begin errors++; $display("FAIL reset_vo got %b exp 0", video_on_out); end
        checks++; if (frame_start_out !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start_out); end
        checks++; if (bus.address_1_out !== 5'h10) begin errors++; $display("FAIL reset_a1 got %h exp 10", bus.address_1_out); end
        @(negedge clock_in);
        reset_in = 1'b0;
        @(posedge clock_in);
        #1;
        checks++; if (frame_start_out !== 1'b0) begin errors++; $display("FAIL fs_edge1 got %b exp 0", frame_start_out); end
        @(posedge clock_in);
        #1;
        checks++; if (frame_start_out !== 1'b1) begin errors++; $display("FAIL fs_edge2 got %b exp 1", frame_start_out); end
        checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL first_pix got %h exp FFF", rgb_out); end
        oh = 0;
        ov = 0;
    endtask

    // One full frame from output (0,0) to the next (0,0): timing, blanking, pixel and address table
    task automatic test_scan_frame();
        logic exp_vo, exp_hs, exp_vs, exp_fs;
        for (int n = 0; n <= FRAME; n++) begin
            exp_vo = (oh < 640) && (ov < 50);
            exp_hs = !((oh >= 656) && (oh <= 751));
            exp_vs = !((ov == 52) || (ov == 53));
            exp_fs = (oh == 0) && (ov == 0);
            checks++; if (video_on_out !== exp_vo) begin errors++; $display("FAIL vo (%0d,%0d) got %b exp %b", oh, ov, video_on_out, exp_vo); end
            checks++; if (h_sync_out !== exp_hs) begin errors++; $display("FAIL hs (%0d,%0d) got %b exp %b", oh, ov, h_sync_out, exp_hs); end
            checks++; if (v_sync_out !== exp_vs) begin errors++; $display("FAIL vs (%0d,%0d) got %b exp %b", oh, ov, v_sync_out, exp_vs); end
            checks++; if (frame_start_out !== exp_fs) begin errors++; $display("FAIL fs (%0d,%0d) got %b exp %b", oh, ov, frame_start_out, exp_fs); end
            if (!exp_vo) begin
                checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL blank_rgb (%0d,%0d) got %h exp 000", oh, ov, rgb_out); end
            end
            for (int k = 0; k < NPIX; k++) begin
                if ((oh == tx[k]) && (ov == ty[k])) begin
                    checks++; if (rgb_out !== tc[k]) begin errors++; $display("FAIL pix (%0d,%0d) got %h exp %h", oh, ov, rgb_out, tc[k]); end
                end
            end
            // counters run two clocks ahead of the output position
            if ((oh == 238) && (ov == 32)) begin
                checks++; if (bus.address_0_out !== 5'h04) begin errors++; $display("FAIL a0_row2 got %h exp 04", bus.address_0_out); end
                checks++; if (bus.address_1_out !== 5'h14) begin errors++; $display("FAIL a1_row2 got %h exp 14", bus.address_1_out); end
            end
            if ((oh == 494) && (ov == 0)) begin
                checks++; if (bus.address_1_out !== 5'h11) begin errors++; $display("FAIL a1_word1 got %h exp 11", bus.address_1_out); end
            end
            if ((oh == 270) && (ov == 48)) begin
                checks++; if (bus.address_1_out !== 5'h17) begin errors++; $display("FAIL a1_row3 got %h exp 17", bus.address_1_out); end
            end
            if ((oh == 598) && (ov == 10)) begin
                checks++; if (bus.address_0_out !== 5'h00) begin errors++; $display("FAIL a0_off got %h exp 00", bus.address_0_out); end
                checks++; if (bus.address_1_out !== 5'h00) begin errors++; $display("FAIL a1_off got %h exp 00", bus.address_1_out); end
            end
            if (n < FRAME) step();
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard;
        guard = 0;
        while (!((oh == 298) && (ov == 20)) && (guard < 2 * FRAME)) begin
            step();
            guard++;
        end
        checks++; if ((oh != 298) || (ov != 20)) begin errors++; $display("FAIL mid_reach got (%0d,%0d) exp (298,20)", oh, ov); end
        checks++; if (video_on_out !== 1'b1) begin errors++; $display("FAIL mid_vo_pre got %b exp 1", video_on_out); end
        reset_in = 1'b1;
        #1;
        checks++; if (video_on_out !== 1'b0) begin errors++; $display("FAIL mid_vo got %b exp 0", video_on_out); end
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL mid_rgb got %h exp 000", rgb_out); end
        checks++; if (h_sync_out !== 1'b1) begin errors++; $display("FAIL mid_hs got %b exp 1", h_sync_out); end
        checks++; if (v_sync_out !== 1'b1) begin errors++; $display("FAIL mid_vs got %b exp 1", v_sync_out); end
        checks++; if (bus.address_1_out !== 5'h10) begin errors++; $display("FAIL mid_a1 got %h exp 10", bus.address_1_out); end
        repeat (3) @(negedge clock_in);
        reset_in = 1'b0;
        @(posedge clock_in);
        #1;
        checks++; if (frame_start_out !== 1'b0) begin errors++; $display("FAIL mid_fs1 got %b exp 0", frame_start_out); end
        @(posedge clock_in);
        #1;
        checks++; if (frame_start_out !== 1'b1) begin errors++; $display("FAIL mid_fs2 got %b exp 1", frame_start_out); end
        checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL mid_pix got %h exp FFF", rgb_out); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h8000;   // plane 0, row 0, word 0: leftmost pixel
        mem[1]  = 16'h0001;   // plane 0, row 0, word 1: rightmost pixel
        mem[4]  = 16'h0001;   // plane 0, row 2, word 0
        mem[20] = 16'h0001;   // plane 1, row 2, word 0
        mem[23] = 16'h4000;   // plane 1, row 3, word 1, second pixel
        bus.data_0_in = 16'h0000;
        bus.data_1_in = 16'h0000;

        tx[0]  = 0;   ty[0]  = 0;  tc[0]  = 12'hFFF;
        tx[1]  = 15;  ty[1]  = 15; tc[1]  = 12'hFFF;
        tx[2]  = 16;  ty[2]  = 0;  tc[2]  = 12'h000;
        tx[3]  = 0;   ty[3]  = 16; tc[3]  = 12'h000;
        tx[4]  = 496; ty[4]  = 0;  tc[4]  = 12'hFFF;
        tx[5]  = 511; ty[5]  = 15; tc[5]  = 12'hFFF;
        tx[6]  = 512; ty[6]  = 0;  tc[6]  = BORDER_EXP;
        tx[7]  = 240; ty[7]  = 32; tc[7]  = 12'h00F;
        tx[8]  = 255; ty[8]  = 47; tc[8]  = 12'h00F;
        tx[9]  = 239; ty[9]  = 32; tc[9]  = 12'h000;
        tx[10] = 256; ty[10] = 40; tc[10] = 12'h000;
        tx[11] = 272; ty[11] = 48; tc[11] = 12'hF00;
        tx[12] = 287; ty[12] = 49; tc[12] = 12'hF00;
        tx[13] = 600; ty[13] = 10; tc[13] = BORDER_EXP;
        tx[14] = 700; ty[14] = 10; tc[14] = 12'h000;

        test_reset();
        test_scan_frame();
        test_reset_mid_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
